// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner with leading-zero blanking.
// Define SEG7_HEX_EN to show A-F for codes 10-15; otherwise a dash.
module seg7_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   sh_data;
  logic [DIGITS-1:0]     sh_dp;
  logic                  tick;
  logic                  wrap;
  logic [3:0]            code;
  logic                  dp_cur;
  logic                  hi_zero;
  logic                  blank;
  logic [6:0]            font;

  assign tick = (cnt == CW'(DIV - 1));
  assign wrap = tick && (idx == IW'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      sh_data <= '0;
      sh_dp   <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick)
        idx <= wrap ? '0 : idx + IW'(1);
      if (load) begin
        sh_data <= data;
        sh_dp   <= dp_in;
      end
    end
  end

  // hi_zero: active digit and every digit above it are zero
  always_comb begin
    code    = 4'h0;
    dp_cur  = 1'b0;
    hi_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        code   = sh_data[4*i +: 4];
        dp_cur = sh_dp[i];
      end
    end
    for (int j = 0; j < DIGITS; j++) begin
      if (IW'(j) >= idx && sh_data[4*j +: 4] != 4'h0)
        hi_zero = 1'b0;
    end
  end

  assign blank = blank_en && (idx != '0) && hi_zero;

  always_comb begin
    font = 7'b1000000;
    unique case (code)
      4'h0: font = 7'b0111111;
      4'h1: font = 7'b0000110;
      4'h2: font = 7'b1011011;
      4'h3: font = 7'b1001111;
      4'h4: font = 7'b1100110;
      4'h5: font = 7'b1101101;
      4'h6: font = 7'b1111101;
      4'h7: font = 7'b0000111;
      4'h8: font = 7'b1111111;
      4'h9: font = 7'b1101111;
`ifdef SEG7_HEX_EN
      4'hA: font = 7'b1110111;
      4'hB: font = 7'b1111100;
      4'hC: font = 7'b0111001;
      4'hD: font = 7'b1011110;
      4'hE: font = 7'b1111001;
      4'hF: font = 7'b1110001;
`else
      default: font = 7'b1000000;
`endif
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg        <= '0;
      dp         <= 1'b0;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      seg        <= blank ? 7'b0000000 : font;
      dp         <= dp_cur;
      an         <= DIGITS'(1) << idx;
      frame_done <= wrap;
    end
  end

endmodule
